// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int unsigned UART_DATA_W       = 8;
    localparam int unsigned UART_STATE_W      = 3;
    localparam int unsigned UART_BPS_DEFAULT  = 10417;
    localparam int unsigned UART_HALF_DEFAULT = UART_BPS_DEFAULT / 2 - 1;

    typedef enum logic [UART_STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_e;

    // Timer value at which the start bit is re-checked (mid start bit).
    function automatic int unsigned half_bit_cmp(input int unsigned bps);
        return bps / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit timer: counts 0..BPS_PARA-1 and wraps; flags the half-bit and last-count positions.
module uart_rx_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned BPS_PARA = 10417,
    parameter int unsigned CNT_W    = 14
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr_i,
    input  logic en_i,
    output logic half_tick_c_o,
    output logic full_tick_c_o
);

    localparam logic [CNT_W-1:0] FULL_CMP = CNT_W'(BPS_PARA - 1);
    localparam logic [CNT_W-1:0] HALF_CMP = CNT_W'(half_bit_cmp(BPS_PARA));

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == FULL_CMP) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Ticks ignore clr_i so the FSM may clear in the same cycle it consumes a tick.
    assign half_tick_c_o = en_i && (cnt_q == HALF_CMP);
    assign full_tick_c_o = en_i && (cnt_q == FULL_CMP);

endmodule

// File: rtl/uart_rx_byte.sv
// UART 8N1 byte receiver with mid-bit sampling and valid/frame-error strobes.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err_o strobe.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned BPS_PARA = 10417,
    parameter int unsigned CNT_W    = 14
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   rx_en_i,
    input  logic                   rx_i,
    output logic [UART_DATA_W-1:0] data_o,
    output logic                   rx_valid_o,
    output logic                   frame_err_o,
    output logic                   busy_o
`ifdef UART_RX_PARITY_EN
    ,
    output logic                   parity_err_o
`endif
);

    localparam int unsigned IDX_W = $clog2(UART_DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_W - 1);

    logic                   sync1_q;
    logic                   rx_s_q;
    logic                   prev_q;
    rx_state_e              state_q, state_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_q, par_d;
    logic                   perr_q, perr_d;
`endif

    logic fall_c;
    logic tmr_clr_c;
    logic tmr_en_c;
    logic half_tick_c;
    logic full_tick_c;

    uart_rx_bit_timer #(
        .BPS_PARA (BPS_PARA),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk           (clk),
        .rstn          (rstn),
        .clr_i         (tmr_clr_c),
        .en_i          (tmr_en_c),
        .half_tick_c_o (half_tick_c),
        .full_tick_c_o (full_tick_c)
    );

    assign fall_c = prev_q & ~rx_s_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        tmr_clr_c = 1'b0;
        tmr_en_c  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
        perr_d    = 1'b0;
`endif
        if (!rx_en_i) begin
            state_d   = ST_IDLE;
            tmr_clr_c = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    tmr_clr_c = 1'b1;
                    if (fall_c) begin
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    tmr_en_c = 1'b1;
                    if (half_tick_c) begin
                        if (!rx_s_q) begin
                            tmr_clr_c = 1'b1;
                            idx_d     = '0;
                            state_d   = ST_DATA;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    tmr_en_c = 1'b1;
                    if (full_tick_c) begin
                        shift_d = {rx_s_q, shift_q[UART_DATA_W-1:1]};
                        idx_d   = idx_q + IDX_W'(1);
                        if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    tmr_en_c = 1'b1;
                    if (full_tick_c) begin
                        par_d   = rx_s_q;
                        state_d = ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    tmr_en_c = 1'b1;
                    if (full_tick_c) begin
                        if (rx_s_q) begin
                            state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                            if (^{shift_q, par_q}) begin
                                perr_d = 1'b1;
                            end else begin
                                valid_d = 1'b1;
                                data_d  = shift_q;
                            end
`else
                            valid_d = 1'b1;
                            data_d  = shift_q;
`endif
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_WAIT_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            sync1_q <= rx_i;
            rx_s_q  <= sync1_q;
            prev_q  <= rx_s_q;
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign data_o      = data_q;
    assign rx_valid_o  = valid_q;
    assign frame_err_o = ferr_q;
    assign busy_o      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit; honours UART_RX_PARITY_EN.
module tb_uart_rx_byte;

    localparam int unsigned BPS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 171;
`else
    localparam int LAT = 155;
`endif

    logic       clk;
    logic       rstn;
    logic       rx_en;
    logic       rx;
    logic [7:0] data_o;
    logic       rx_valid;
    logic       ferr;
    logic       busy;
    logic       perr;

    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    int         nvalid      = 0;
    int         nferr       = 0;
    int         nperr       = 0;
    int         nboth       = 0;
    int         last_valid_cyc = 0;
    int         start_cyc   = 0;
    logic [7:0] rxq[$];

    uart_rx_byte #(
        .BPS_PARA (BPS),
        .CNT_W    (14)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .rx_en_i      (rx_en),
        .rx_i         (rx),
        .data_o       (data_o),
        .rx_valid_o   (rx_valid),
        .frame_err_o  (ferr),
        .busy_o       (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err_o (perr)
`endif
    );

`ifndef UART_RX_PARITY_EN
    assign perr = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            nvalid         <= nvalid + 1;
            last_valid_cyc <= cyc;
            rxq.push_back(data_o);
        end
        if (ferr) nferr <= nferr + 1;
        if (perr) nperr <= nperr + 1;
        if (rx_valid && ferr) nboth <= nboth + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        @(posedge clk);
        #1 rx = b;
        repeat (BPS - 1) @(posedge clk);
    endtask

    // Start bit, 8 data bits LSB first, optional even parity (flip to corrupt), stop bit.
    task automatic send_byte(input logic [7:0] d, input logic stop_b, input logic par_flip);
        @(posedge clk);
        #1 rx = 1'b0;
        start_cyc = cyc;
        repeat (BPS - 1) @(posedge clk);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        drive_bit(stop_b);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rstn  = 1'b0;
        rx_en = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data",  32'(data_o),   32'h00);
        check("reset_valid", 32'(rx_valid), 32'h0);
        check("reset_ferr",  32'(ferr),     32'h0);
        check("reset_busy",  32'(busy),     32'h0);
        rstn = 1'b1;
        idle(5);

        // Plain frame and its latency from the start edge.
        send_byte(8'hA5, 1'b1, 1'b0);
        idle(4);
        check("a5_nvalid",  32'(nvalid), 32'd1);
        check("a5_data",    32'(data_o), 32'hA5);
        check("a5_latency", 32'(last_valid_cyc - start_cyc), 32'(LAT));
        check("a5_ferr",    32'(nferr),  32'd0);

        // Short glitch rejected at the half-bit check.
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        check("glitch_busy_hi", 32'(busy), 32'h1);
        idle(20);
        check("glitch_busy_lo", 32'(busy),   32'h0);
        check("glitch_nvalid",  32'(nvalid), 32'd1);
        check("glitch_nferr",   32'(nferr),  32'd0);

        // Framing error, then a held-low line that must not start a frame.
        send_byte(8'h3C, 1'b0, 1'b0);
        idle(40);
        check("ferr_count",   32'(nferr),  32'd1);
        check("ferr_nvalid",  32'(nvalid), 32'd1);
        check("ferr_data",    32'(data_o), 32'hA5);
        check("ferr_wait",    32'(busy),   32'h1);
        rx = 1'b1;
        idle(20);
        check("ferr_recover", 32'(busy),   32'h0);
        send_byte(8'h81, 1'b1, 1'b0);
        idle(4);
        check("x81_nvalid", 32'(nvalid), 32'd2);
        check("x81_data",   32'(data_o), 32'h81);
        check("x81_nferr",  32'(nferr),  32'd1);

        // Back-to-back frames with zero idle gap.
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0);
        idle(4);
        check("b2b_nvalid", 32'(nvalid), 32'd4);
        check("b2b_first",  32'(rxq[2]), 32'h00);
        check("b2b_second", 32'(rxq[3]), 32'hFF);

        // Reset pulse during bit 4 discards the frame.
        fork
            send_byte(8'hFE, 1'b1, 1'b0);
            begin
                repeat (88) @(posedge clk);
                #1 rstn = 1'b0;
                @(posedge clk);
                #1 rstn = 1'b1;
            end
        join
        idle(10);
        check("rst_nvalid", 32'(nvalid), 32'd4);
        check("rst_data",   32'(data_o), 32'h00);
        check("rst_busy",   32'(busy),   32'h0);
        send_byte(8'h5A, 1'b1, 1'b0);
        idle(4);
        check("x5a_nvalid", 32'(nvalid), 32'd5);
        check("x5a_data",   32'(data_o), 32'h5A);

        // Enable drop during bit 4 discards the frame, data kept.
        fork
            send_byte(8'hFE, 1'b1, 1'b0);
            begin
                repeat (88) @(posedge clk);
                #1 rx_en = 1'b0;
                @(posedge clk);
                #1 rx_en = 1'b1;
            end
        join
        idle(10);
        check("en_nvalid", 32'(nvalid), 32'd5);
        check("en_data",   32'(data_o), 32'h5A);
        check("en_busy",   32'(busy),   32'h0);
        send_byte(8'h3C, 1'b1, 1'b0);
        idle(4);
        check("x3c_nvalid", 32'(nvalid), 32'd6);
        check("x3c_data",   32'(data_o), 32'h3C);

`ifdef UART_RX_PARITY_EN
        send_byte(8'h07, 1'b1, 1'b1);
        idle(4);
        check("par_bad_nperr",  32'(nperr),  32'd1);
        check("par_bad_nvalid", 32'(nvalid), 32'd6);
        check("par_bad_data",   32'(data_o), 32'h3C);
        send_byte(8'h07, 1'b1, 1'b0);
        idle(4);
        check("par_ok_nvalid", 32'(nvalid), 32'd7);
        check("par_ok_data",   32'(data_o), 32'h07);
        check("par_ok_nperr",  32'(nperr),  32'd1);
`else
        check("no_perr", 32'(nperr), 32'd0);
`endif
        check("valid_ferr_excl", 32'(nboth), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
